ram_burst_master: RTL

// Command-driven access engine (initiator) for the single-port RAM: sync write, combinational read.

---
 rtl/ram_burst_master_if.sv | 68 ++++++
 rtl/ram_burst_master.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_master_if.sv
// Command, read-stream and RAM-port bundle for ram_burst_master.
// master: the engine; slave: command source, read sink and RAM.
interface ram_burst_master_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
);
  // command port (valid/ready)
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH:0]   cmd_len;
  logic [DATA_WIDTH-1:0] cmd_data;
  // read stream (valid/ready)
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;
  // RAM port: sync write, combinational read
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;
  // status
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_addr,
    input  cmd_len,
    input  cmd_data,
    output cmd_ready,
    output rd_valid,
    input  rd_ready,
    output rd_data,
    output rd_last,
    output ram_we,
    output ram_addr,
    output ram_wdata,
    input  ram_rdata,
    output busy,
    output done,
    output err
  );

  modport slave (
    output cmd_valid,
    output cmd_op,
    output cmd_addr,
    output cmd_len,
    output cmd_data,
    input  cmd_ready,
    input  rd_valid,
    output rd_ready,
    input  rd_data,
    input  rd_last,
    input  ram_we,
    input  ram_addr,
    input  ram_wdata,
    output ram_rdata,
    input  busy,
    input  done,
    input  err
  );
endinterface

// File: rtl/ram_burst_master.sv
// Command-driven access engine and sole owner of a single-port RAM.
// Commands: fill const (00), fill incr (01), burst read (10); 11 rejected.
// Ports: i_CLK, i_RSTn (async, active low), bus (ram_burst_master_if.master):
//   cmd_*  command valid/ready with op/addr/len/data
//   rd_*   read beat stream valid/ready/data/last
//   ram_*  RAM write enable, address, write data, comb read data
//   busy/done/err  status; done and err are single-cycle pulses
module ram_burst_master #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input logic                i_CLK,
  input logic                i_RSTn,
  ram_burst_master_if.master bus
);

  localparam logic [ADDR_WIDTH:0] DEPTH =
    {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE =
    {{ADDR_WIDTH{1'b0}}, 1'b1};

  localparam logic [1:0] OP_INCR = 2'b01;
  localparam logic [1:0] OP_READ = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DONE,
    ERR
  } state_t;

  state_t state;
  state_t state_nx;

  logic                  accept;
  logic                  len_ok;
  logic                  cmd_bad;
  logic                  cmd_rd;
  logic                  cmd_wr;
  logic                  fetch;
  logic                  pop;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  incr_q;
  // words still to write (WRITE) or still to fetch (READ)
  logic [ADDR_WIDTH:0]   cnt_q;

  logic                  rd_valid_q;
  logic                  rd_last_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  assign accept = bus.cmd_valid && (state == IDLE);

  always_comb begin
    cmd_bad = 1'b0;
    cmd_rd  = 1'b0;
    cmd_wr  = 1'b0;
    len_ok  = (bus.cmd_len != '0)
           && (bus.cmd_len <= DEPTH);
    unique case (1'b1)
      (!len_ok || bus.cmd_op == OP_RSVD):
        cmd_bad = 1'b1;
      (len_ok && bus.cmd_op == OP_READ):
        cmd_rd = 1'b1;
      (len_ok && !bus.cmd_op[1]):
        cmd_wr = 1'b1;
      default:
        cmd_bad = 1'b1;
    endcase
  end

  // the output slot refills whenever it is empty or being drained
  assign pop   = rd_valid_q && bus.rd_ready;
  assign fetch = (state == READ)
              && (cnt_q != '0)
              && (!rd_valid_q || bus.rd_ready);

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    bus.cmd_ready = 1'b0;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    bus.ram_we    = 1'b0;
    unique case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.busy      = 1'b0;
        if (accept) begin
          unique case (1'b1)
            cmd_bad: state_nx = ERR;
            cmd_rd:  state_nx = READ;
            cmd_wr:  state_nx = WRITE;
            default: state_nx = ERR;
          endcase
        end
      end
      WRITE: begin
        bus.ram_we = 1'b1;
        if (cnt_q == ONE) begin
          state_nx = DONE;
        end
      end
      READ: begin
        if (pop && rd_last_q) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        state_nx = IDLE;
      end
      ERR: begin
        bus.err  = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      incr_q     <= 1'b0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      if (accept) begin
        addr_q  <= bus.cmd_addr;
        wdata_q <= bus.cmd_data;
        incr_q  <= (bus.cmd_op == OP_INCR);
        cnt_q   <= cmd_bad ? '0 : bus.cmd_len;
      end else if (state == WRITE) begin
        addr_q <= addr_q + 1'b1;
        cnt_q  <= cnt_q - ONE;
        if (incr_q) begin
          wdata_q <= wdata_q + 1'b1;
        end
      end else if (fetch) begin
        addr_q <= addr_q + 1'b1;
        cnt_q  <= cnt_q - ONE;
      end

      if (fetch) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= bus.ram_rdata;
        rd_last_q  <= (cnt_q == ONE);
      end else if (pop) begin
        rd_valid_q <= 1'b0;
        rd_last_q  <= 1'b0;
      end
    end
  end

  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_last   = rd_last_q;

  a_stall_stable: assert property (
    @(posedge i_CLK) disable iff (!i_RSTn)
    (rd_valid_q && !bus.rd_ready)
      |=> (rd_valid_q
           && $stable(rd_data_q)
           && $stable(rd_last_q)
           && $stable(addr_q))
  );

  a_last_valid: assert property (
    @(posedge i_CLK) disable iff (!i_RSTn)
    rd_last_q |-> rd_valid_q
  );

endmodule
